mem_bus_if: RTL
===============

Name: mem_bus_if

Overview:
Memory bus interface between the SM83 control/datapath and the external memory bus. It takes the per-M-cycle address select and read/write strobes from the control unit and resolves the 16-bit address from PC, GP16, WZ or FF00+C. It runs a valid/ready transaction with a timeout on the external bus. It stalls the core until the access completes and returns read data for IR, Z, W or r8 capture.

Parameters:
TIMEOUT, 16, max BUSY cycles waiting for bus_ready before abort (>=1)
OPEN_BUS, 8'hFF, read data returned on aborted or no-address reads

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
addr_sel  in  addr_sel_t  address source: PC, GP16, WZ, FF_C, NONE
pc  in  16  program counter
gp16  in  16  selected 16-bit register pair
wz  in  16  WZ temp pair
c_reg  in  8  C register (FF_C page offset)
rd_en  in  1  read request (OR of mem_to_ir/z/w/r8)
wr_en  in  1  write request (OR of r8_to_mem/z_to_mem)
wr_data  in  8  write byte from core
stall  out  1  core must hold all control state this cycle
rd_data  out  8  read byte to core, valid when rd_valid
rd_valid  out  1  read completes this cycle
bus_addr  out  16  registered transaction address
bus_wdata  out  8  registered write data
bus_we  out  1  1 = write, 0 = read
bus_valid  out  1  transaction outstanding
bus_ready  in  1  target accepts/completes in this cycle
bus_rdata  in  8  read data, sampled when bus_valid & bus_ready
bus_err  out  1  sticky: timeout occurred
req_conflict  out  1  sticky: rd_en & wr_en seen together

Behaviour:
- Reset (async, immediate): state IDLE, bus_valid=0, bus_we=0, bus_addr=0, bus_wdata=0, timeout count=0, bus_err=0, req_conflict=0. Outputs stall=0 and rd_valid=0 while reset is asserted.
- Address decode (comb): PC->pc, GP16->gp16, WZ->wz, FF_C->{8'hFF,c_reg}.
- req = (rd_en|wr_en) & addr_sel!=NONE. dir: wr_en has priority when both strobes are high. rd_en&wr_en sets req_conflict.
- Request with addr_sel==NONE: no bus transaction and stall=0. If rd_en is set, rd_valid=1 and rd_data=OPEN_BUS in the same cycle.
- FSM IDLE:
  - req -> stall=1. Latch bus_addr, bus_we, bus_wdata (wr_data) at the edge. Set bus_valid=1 and count=0, then go to BUSY.
  - Otherwise stall=0.
  - bus_ready is ignored in IDLE.
- FSM BUSY (bus_valid=1, address/data held stable):
  - bus_ready=1 -> stall=0. On a read: rd_valid=1 and rd_data=bus_rdata (combinational pass-through) this cycle. Next edge: bus_valid=0, go to IDLE.
  - bus_ready=0 and count<TIMEOUT-1 -> stall=1, count+1.
  - bus_ready=0 and count==TIMEOUT-1 -> abort. stall=0; on a read, rd_valid=1 and rd_data=OPEN_BUS. Set bus_err, bus_valid=0, go to IDLE.
- Minimum access latency: 2 cycles (IDLE latch + BUSY with ready). The core sees stall in the first cycle.
- The core holds addr_sel, strobes and wr_data stable while stall=1. Input changes during BUSY are ignored.
- Back-to-back: after completion the FSM returns to IDLE. The next request starts in that cycle; there is no turnaround bubble beyond the IDLE latch cycle.
- rd_valid is never 1 for writes. rd_data=0 when rd_valid=0.
- Sticky flags clear only on reset.

Test Plan:
- Read via PC=0x0150, bus_ready high on the first BUSY cycle, bus_rdata=0x3E -> stall 1 cycle, bus_addr=0x0150, bus_we=0, rd_valid=1 with rd_data=0x3E in cycle 2, bus_valid low in cycle 3.
- Write FF_C with c_reg=0x44, wr_data=0xA5, bus_ready after 3 wait cycles -> bus_addr=0xFF44, bus_wdata=0xA5, bus_we=1, stall high for 4 cycles, rd_valid never set.
- Read GP16=0xC000 with bus_ready held low and TIMEOUT=16 -> abort after 16 BUSY cycles, rd_data=0xFF, rd_valid=1, bus_err=1 and stays 1.
- rd_en=1 with addr_sel=NONE -> no bus_valid, stall=0, rd_valid=1, rd_data=0xFF the same cycle.
- rd_en=wr_en=1 to WZ=0x8000 -> write transaction issued (bus_we=1), req_conflict=1.
- Deassert rst_n while BUSY -> bus_valid drops immediately, stall=0. After release, the FSM is IDLE and a new PC read completes normally.

Source files
------------

// File: rtl/mem_bus_if_if.sv
// External memory bus bundle between the core-side bus interface (master)
// and the memory/peripheral target (slave).
interface mem_bus_if_if;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_we;
    logic        bus_valid;
    logic        bus_ready;
    logic [7:0]  bus_rdata;

    modport master (
        output bus_addr, bus_wdata, bus_we, bus_valid,
        input  bus_ready, bus_rdata
    );

    modport slave (
        input  bus_addr, bus_wdata, bus_we, bus_valid,
        output bus_ready, bus_rdata
    );
endinterface

// File: rtl/mem_bus_if.sv
// SM83 memory bus interface: resolves the M-cycle address, runs one valid/ready
// transaction with timeout, and stalls the core until the access completes.
package mem_bus_if_pkg;
    typedef enum logic [2:0] {
        ADDR_PC   = 3'd0,
        ADDR_GP16 = 3'd1,
        ADDR_WZ   = 3'd2,
        ADDR_FF_C = 3'd3,
        ADDR_NONE = 3'd4
    } addr_sel_t;
endpackage

module mem_bus_if
    import mem_bus_if_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [7:0]  OPEN_BUS = 8'hFF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  addr_sel_t    addr_sel_i,
    input  logic [15:0]  pc_i,
    input  logic [15:0]  gp16_i,
    input  logic [15:0]  wz_i,
    input  logic [7:0]   c_reg_i,
    input  logic         rd_en_i,
    input  logic         wr_en_i,
    input  logic [7:0]   wr_data_i,
    output logic         stall_o,
    output logic [7:0]   rd_data_o,
    output logic         rd_valid_o,
    output logic         bus_err_o,
    output logic         req_conflict_o,
    mem_bus_if_if.master bus
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        conflict_q, conflict_d;

    logic [15:0] addr_mux;
    logic        req;
    logic        stall_c;
    logic        rd_valid_c;
    logic [7:0]  rd_data_c;

    // Address source decode
    always_comb begin
        addr_mux = 16'h0000;
        case (addr_sel_i)
            ADDR_PC:   addr_mux = pc_i;
            ADDR_GP16: addr_mux = gp16_i;
            ADDR_WZ:   addr_mux = wz_i;
            ADDR_FF_C: addr_mux = {8'hFF, c_reg_i};
            default:   addr_mux = 16'h0000;
        endcase
    end

    assign req = (rd_en_i | wr_en_i) && (addr_sel_i != ADDR_NONE);

    // Next-state and core-facing handshake
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        valid_d    = valid_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        conflict_d = conflict_q | (rd_en_i & wr_en_i);
        stall_c    = 1'b0;
        rd_valid_c = 1'b0;
        rd_data_c  = 8'h00;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    stall_c = 1'b1;
                    addr_d  = addr_mux;
                    we_d    = wr_en_i;
                    wdata_d = wr_data_i;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end else if (rd_en_i && !wr_en_i) begin
                    // Read with no address source: float-high bus value, no transaction
                    rd_valid_c = 1'b1;
                    rd_data_c  = OPEN_BUS;
                end
            end
            S_BUSY: begin
                if (bus.bus_ready) begin
                    if (!we_q) begin
                        rd_valid_c = 1'b1;
                        rd_data_c  = bus.bus_rdata;
                    end
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    if (!we_q) begin
                        rd_valid_c = 1'b1;
                        rd_data_c  = OPEN_BUS;
                    end
                    err_d   = 1'b1;
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= 16'h0000;
            wdata_q    <= 8'h00;
            we_q       <= 1'b0;
            valid_q    <= 1'b0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            valid_q    <= valid_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            conflict_q <= conflict_d;
        end
    end

    // Core handshake is forced quiet while reset is held
    assign stall_o        = rst_n & stall_c;
    assign rd_valid_o     = rst_n & rd_valid_c;
    assign rd_data_o      = rd_valid_o ? rd_data_c : 8'h00;
    assign bus_err_o      = err_q;
    assign req_conflict_o = conflict_q;

    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = wdata_q;
    assign bus.bus_we    = we_q;
    assign bus.bus_valid = valid_q;

endmodule
